hazard_ctrl_unit: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RISC-V core, sitting between the decoder/pipeline registers and the PC/IF-ID/ID-EX/EX-MEM write enables. It has four functions:
- detects load-use hazards and inserts a configurable number of bubbles;
- freezes the front of the pipeline while a multi-cycle EX operation (mul/div) completes;
- flushes wrong-path instructions on a taken branch;
- drives the EX-stage forwarding selects and keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_ctrl_unit.sv | 182 ++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage core: load-use bubbles, multi-cycle EX freeze,
// branch flush, EX operand forwarding and a saturating stall-cycle counter.
module hazard_ctrl_unit #(
    parameter int REG_W        = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int MC_LAT       = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_mc_start,
    input  logic             branch_taken,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             if_id_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MAX_CYC = (LOAD_BUBBLES > MC_LAT) ? LOAD_BUBBLES : MC_LAT;
    localparam int REM_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam bit MC_STALLS = (MC_LAT > 1);
    localparam bit MC_HOLD   = (MC_LAT > 2);
    localparam bit LU_HOLD   = (LOAD_BUBBLES > 1);

    // rem counts the stall cycles still owed after the current one; the trigger cycle in RUN
    // is itself the first stall cycle, so a multi-cycle op owes MC_LAT-2 further cycles.
    localparam logic [REM_W-1:0] LU_INIT = LU_HOLD ? REM_W'(LOAD_BUBBLES - 2) : '0;
    localparam logic [REM_W-1:0] MC_INIT = MC_HOLD ? REM_W'(MC_LAT - 3) : '0;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MC_BUSY    = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_nxt;

    logic lu;
    logic pc_write_c;
    logic if_id_write_c;
    logic id_ex_write_c;
    logic id_ex_bubble_c;
    logic ex_mem_bubble_c;
    logic if_id_flush_c;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] m_rd,
        input logic             m_we,
        input logic [REG_W-1:0] w_rd,
        input logic             w_we
    );
        if (m_we && (m_rd != '0) && (m_rd == rs)) begin
            return 2'b10;
        end else if (w_we && (w_rd != '0) && (w_rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign lu = ex_mem_read && (ex_rd != '0) &&
                ((id_rs1_used && (ex_rd == id_rs1)) || (id_rs2_used && (ex_rd == id_rs2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        rem_nxt         = rem;
        pc_write_c      = 1'b1;
        if_id_write_c   = 1'b1;
        id_ex_write_c   = 1'b1;
        id_ex_bubble_c  = 1'b0;
        ex_mem_bubble_c = 1'b0;
        if_id_flush_c   = 1'b0;

        case (state)
            RUN: begin
                if (branch_taken) begin
                    if_id_flush_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                end else if (ex_mc_start && MC_STALLS) begin
                    pc_write_c      = 1'b0;
                    if_id_write_c   = 1'b0;
                    id_ex_write_c   = 1'b0;
                    ex_mem_bubble_c = 1'b1;
                    if (MC_HOLD) begin
                        state_nxt = MC_BUSY;
                        rem_nxt   = MC_INIT;
                    end
                end else if (lu) begin
                    pc_write_c     = 1'b0;
                    if_id_write_c  = 1'b0;
                    id_ex_bubble_c = 1'b1;
                    if (LU_HOLD) begin
                        state_nxt = LOAD_STALL;
                        rem_nxt   = LU_INIT;
                    end
                end
            end
            LOAD_STALL: begin
                pc_write_c     = 1'b0;
                if_id_write_c  = 1'b0;
                id_ex_bubble_c = 1'b1;
                if (rem == '0) begin
                    state_nxt = RUN;
                end else begin
                    rem_nxt = rem - REM_W'(1);
                end
            end
            MC_BUSY: begin
                pc_write_c      = 1'b0;
                if_id_write_c   = 1'b0;
                id_ex_write_c   = 1'b0;
                ex_mem_bubble_c = 1'b1;
                if (rem == '0) begin
                    state_nxt = RUN;
                end else begin
                    rem_nxt = rem - REM_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                rem_nxt   = '0;
            end
        endcase
    end

    // Reset forces a free-flowing pipeline immediately, independent of any clock edge.
    assign pc_write      = pc_write_c | ~rst_n;
    assign if_id_write   = if_id_write_c | ~rst_n;
    assign id_ex_write   = id_ex_write_c | ~rst_n;
    assign id_ex_bubble  = id_ex_bubble_c & rst_n;
    assign ex_mem_bubble = ex_mem_bubble_c & rst_n;
    assign if_id_flush   = if_id_flush_c & rst_n;
    assign busy          = (state != RUN) && rst_n;

    assign fwd_a = rst_n ? fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write) : 2'b00;
    assign fwd_b = rst_n ? fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!pc_write_c) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: two parameterisations share one stimulus stream,
// a cycle-timeline reference model predicts outputs and a negedge monitor compares them.
module tb_hazard_ctrl_unit;

    localparam int LB0 = 1, MC0 = 4, CW0 = 16;
    localparam int LB1 = 2, MC1 = 3, CW1 = 3;

    typedef struct {
        logic       rst_n;
        logic [4:0] id_rs1, id_rs2;
        logic       id_rs1_used, id_rs2_used;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       ex_mem_read, ex_mc_start, branch_taken;
        logic [4:0] mem_rd;
        logic       mem_reg_write;
        logic [4:0] wb_rd;
        logic       wb_reg_write;
    } stim_t;

    typedef struct {
        int         cyc;
        logic [6:0] ctl;   // {pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, if_id_flush, busy}
        logic [3:0] fwd;   // {fwd_a, fwd_b}
        int         cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rs1 = '0, ex_rs2 = '0, ex_rd = '0, mem_rd = '0, wb_rd = '0;
    logic id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_mem_read = 1'b0, ex_mc_start = 1'b0;
    logic branch_taken = 1'b0, mem_reg_write = 1'b0, wb_reg_write = 1'b0;

    logic pw0, iw0, xw0, xb0, mb0, fl0, bz0;
    logic pw1, iw1, xw1, xb1, mb1, fl1, bz1;
    logic [1:0] fa0, fb0, fa1, fb1;
    logic [CW0-1:0] cnt0;
    logic [CW1-1:0] cnt1;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_W(5), .LOAD_BUBBLES(LB0), .MC_LAT(MC0), .CNT_W(CW0)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_mc_start(ex_mc_start), .branch_taken(branch_taken),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .pc_write(pw0), .if_id_write(iw0), .id_ex_write(xw0), .id_ex_bubble(xb0),
        .ex_mem_bubble(mb0), .if_id_flush(fl0), .fwd_a(fa0), .fwd_b(fb0), .busy(bz0),
        .stall_cnt(cnt0)
    );

    hazard_ctrl_unit #(.REG_W(5), .LOAD_BUBBLES(LB1), .MC_LAT(MC1), .CNT_W(CW1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_mc_start(ex_mc_start), .branch_taken(branch_taken),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .pc_write(pw1), .if_id_write(iw1), .id_ex_write(xw1), .id_ex_bubble(xb1),
        .ex_mem_bubble(mb1), .if_id_flush(fl1), .fwd_a(fa1), .fwd_b(fb1), .busy(bz1),
        .stall_cnt(cnt1)
    );

    // Reference model: a stall is a window of cycle numbers [trigger, lock_end[k]].
    int   cyc = 0;
    int   lock_end [2] = '{-1, -1};
    bit   lock_mc  [2] = '{1'b0, 1'b0};
    int   cnt_m    [2] = '{0, 0};
    exp_t q0[$];
    exp_t q1[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
        if (s.mem_reg_write && s.mem_rd != 0 && s.mem_rd == rs) return 2'b10;
        if (s.wb_reg_write && s.wb_rd != 0 && s.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model(input int k, input stim_t s);
        exp_t e;
        int   lb, mc, cmax;
        bit   pw, iw, xw, xb, mb, fl, bz, lu;
        lb   = (k == 0) ? LB0 : LB1;
        mc   = (k == 0) ? MC0 : MC1;
        cmax = (k == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
        e.cyc = cyc;
        if (!s.rst_n) begin
            lock_end[k] = -1;
            cnt_m[k]    = 0;
            e.ctl = 7'b1110000;
            e.fwd = 4'b0000;
            e.cnt = 0;
            return e;
        end
        e.fwd = {ref_fwd(s.ex_rs1, s), ref_fwd(s.ex_rs2, s)};
        e.cnt = cnt_m[k];
        lu = s.ex_mem_read && s.ex_rd != 0 &&
             ((s.id_rs1_used && s.ex_rd == s.id_rs1) || (s.id_rs2_used && s.ex_rd == s.id_rs2));
        {pw, iw, xw, xb, mb, fl, bz} = 7'b1110000;
        if (cyc <= lock_end[k]) begin
            bz = 1'b1;
            if (lock_mc[k]) {pw, iw, xw, mb} = 4'b0001;
            else {pw, iw, xb} = 3'b001;
        end else if (s.branch_taken) begin
            fl = 1'b1;
            xb = 1'b1;
        end else if (s.ex_mc_start && mc > 1) begin
            {pw, iw, xw, mb} = 4'b0001;
            if (mc > 2) begin
                lock_end[k] = cyc + mc - 2;
                lock_mc[k]  = 1'b1;
            end
        end else if (lu) begin
            {pw, iw, xb} = 3'b001;
            if (lb > 1) begin
                lock_end[k] = cyc + lb - 1;
                lock_mc[k]  = 1'b0;
            end
        end
        e.ctl = {pw, iw, xw, xb, mb, fl, bz};
        if (!pw && cnt_m[k] < cmax) cnt_m[k]++;
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1;
        s.id_rs1 = '0; s.id_rs2 = '0; s.id_rs1_used = 1'b0; s.id_rs2_used = 1'b0;
        s.ex_rs1 = '0; s.ex_rs2 = '0; s.ex_rd = '0;
        s.ex_mem_read = 1'b0; s.ex_mc_start = 1'b0; s.branch_taken = 1'b0;
        s.mem_rd = '0; s.mem_reg_write = 1'b0; s.wb_rd = '0; s.wb_reg_write = 1'b0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        @(posedge clk);
        #1;
        rst_n = s.rst_n;
        id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
        id_rs1_used = s.id_rs1_used; id_rs2_used = s.id_rs2_used;
        ex_rs1 = s.ex_rs1; ex_rs2 = s.ex_rs2; ex_rd = s.ex_rd;
        ex_mem_read = s.ex_mem_read; ex_mc_start = s.ex_mc_start; branch_taken = s.branch_taken;
        mem_rd = s.mem_rd; mem_reg_write = s.mem_reg_write;
        wb_rd = s.wb_rd; wb_reg_write = s.wb_reg_write;
        q0.push_back(model(0, s));
        q1.push_back(model(1, s));
        cyc++;
    endtask

    task automatic check(input string name, input int c, input int k, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL cyc=%0d dut%0d %s got=%0h expected=%0h", c, k, name, got, exp);
    endtask

    // Monitor: pops one prediction per DUT each cycle, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("ctl", e.cyc, 0, int'({pw0, iw0, xw0, xb0, mb0, fl0, bz0}), int'(e.ctl));
                check("fwd", e.cyc, 0, int'({fa0, fb0}), int'(e.fwd));
                check("stall_cnt", e.cyc, 0, int'(cnt0), e.cnt);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("ctl", e.cyc, 1, int'({pw1, iw1, xw1, xb1, mb1, fl1, bz1}), int'(e.ctl));
                check("fwd", e.cyc, 1, int'({fa1, fb1}), int'(e.fwd));
                check("stall_cnt", e.cyc, 1, int'(cnt1), e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        // Reset with matching forwarding inputs: outputs must stay forced.
        s = idle(); s.rst_n = 1'b0; s.ex_rs1 = 7; s.mem_rd = 7; s.mem_reg_write = 1'b1;
        s.ex_mem_read = 1'b1; s.ex_rd = 7; s.id_rs1 = 7; s.id_rs1_used = 1'b1;
        apply(s); apply(s);
        s = idle(); apply(s);
        // Load-use on rs1
        s = idle(); s.ex_mem_read = 1'b1; s.ex_rd = 5; s.id_rs1 = 5; s.id_rs1_used = 1'b1;
        apply(s);
        s = idle(); repeat (3) apply(s);
        // Load to x0, and a match only on an unused source
        s = idle(); s.ex_mem_read = 1'b1; s.ex_rd = 0; s.id_rs1 = 0; s.id_rs1_used = 1'b1;
        apply(s);
        s = idle(); s.ex_mem_read = 1'b1; s.ex_rd = 6; s.id_rs2 = 6; s.id_rs1 = 3; s.id_rs1_used = 1'b1;
        apply(s);
        // Multi-cycle op with a branch pulse arriving while busy
        s = idle(); s.ex_mc_start = 1'b1; apply(s);
        s = idle(); s.branch_taken = 1'b1; apply(s);
        s = idle(); repeat (3) apply(s);
        // Branch together with load-use
        s = idle(); s.branch_taken = 1'b1; s.ex_mem_read = 1'b1; s.ex_rd = 5; s.id_rs1 = 5; s.id_rs1_used = 1'b1;
        apply(s);
        s = idle(); apply(s);
        // Forwarding priority and x0
        s = idle(); s.ex_rs1 = 7; s.ex_rs2 = 7; s.mem_rd = 7; s.wb_rd = 7;
        s.mem_reg_write = 1'b1; s.wb_reg_write = 1'b1;
        apply(s);
        s.mem_reg_write = 1'b0; apply(s);
        s.ex_rs1 = 0; apply(s);
        // Asynchronous reset in the middle of a multi-cycle stall
        s = idle(); s.ex_mc_start = 1'b1; apply(s);
        s = idle(); apply(s);
        s.rst_n = 1'b0; apply(s);
        s.rst_n = 1'b1; apply(s); apply(s);
        // Randomised traffic over a small register window so hazards are frequent
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst_n = ($urandom_range(0, 99) >= 2);
            s.id_rs1 = 5'($urandom_range(0, 3)); s.id_rs2 = 5'($urandom_range(0, 3));
            s.id_rs1_used = 1'($urandom_range(0, 1)); s.id_rs2_used = 1'($urandom_range(0, 1));
            s.ex_rs1 = 5'($urandom_range(0, 3)); s.ex_rs2 = 5'($urandom_range(0, 3));
            s.ex_rd = 5'($urandom_range(0, 3));
            s.ex_mem_read = ($urandom_range(0, 99) < 35);
            s.ex_mc_start = ($urandom_range(0, 99) < 6);
            s.branch_taken = ($urandom_range(0, 99) < 12);
            s.mem_rd = 5'($urandom_range(0, 3)); s.mem_reg_write = 1'($urandom_range(0, 1));
            s.wb_rd = 5'($urandom_range(0, 3)); s.wb_reg_write = 1'($urandom_range(0, 1));
            apply(s);
        end
        repeat (3) @(negedge clk);
        check("drain", cyc, 0, q0.size(), 0);
        check("drain", cyc, 1, q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
